// File: rtl/instruction_decode_pipe_pkg.sv
// Shared opcode, funct3 and decoded-op encodings for the pipelined decode stage.
// decoded_op_t fixes the bit layout that execute expects on decoded_op_de.
package instruction_decode_pipe_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  // Spare branch code, used by execute as "unconditional" for JAL/JALR.
  localparam logic [2:0] FUNCT3_JUMP = 3'b011;

  localparam logic USE_IN1_RS1 = 1'b0;
  localparam logic USE_IN1_PC  = 1'b1;
  localparam logic USE_IN2_RS2 = 1'b0;
  localparam logic USE_IN2_IMM = 1'b1;

  typedef enum logic [1:0] {
    USE_ALU = 2'd0,
    USE_MEM = 2'd1,
    USE_PC  = 2'd2,
    USE_CMP = 2'd3
  } rd_src_e;

  typedef struct packed {
    logic       must_jump;
    logic       data_mem_we;
    logic       jump_en;
    logic [2:0] funct3;
    rd_src_e    rd_src;
    logic       in2_sel;
    logic       in1_sel;
  } decoded_op_t;

  localparam int OPLEN = $bits(decoded_op_t);

  function automatic logic is_rv32i_op(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_pipe_decode_core.sv
// Purely combinational RV32I field decode: immediate, ALU select, rd and control bits.
// Illegal encodings come out with rd and every control bit cleared.
module decode_core
  import instruction_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      inst,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       funct_alu,
  output logic [4:0]       rd_sel,
  output logic [OPLEN-1:0] decoded_op,
  output logic             illegal,
  output logic             rs1_used,
  output logic             rs2_used
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  decoded_op_t d;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];

  always_comb begin
    d         = '0;
    d.funct3  = f3;
    d.in1_sel = USE_IN1_RS1;
    d.in2_sel = USE_IN2_IMM;
    d.rd_src  = USE_ALU;
    imm       = '0;
    funct_alu = {1'b0, f3};
    rd_sel    = inst[11:7];
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    illegal   = ~is_rv32i_op(opc) | (inst[1:0] != 2'b11);

    case (opc)
      OPC_LUI: begin
        imm       = XLEN'($signed({inst[31:12], 12'h000}));
        funct_alu = '0;
        rs1_used  = 1'b0;
      end
      OPC_AUIPC: begin
        imm       = XLEN'($signed({inst[31:12], 12'h000}));
        d.in1_sel = USE_IN1_PC;
        funct_alu = '0;
        rs1_used  = 1'b0;
      end
      OPC_JAL: begin
        imm       = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        d.in1_sel = USE_IN1_PC;
        d.rd_src  = USE_PC;
        d.funct3  = FUNCT3_JUMP;
        d.jump_en = 1'b1;
        funct_alu = '0;
        rs1_used  = 1'b0;
      end
      OPC_JALR: begin
        imm       = XLEN'($signed(inst[31:20]));
        d.rd_src  = USE_PC;
        d.funct3  = FUNCT3_JUMP;
        d.jump_en = 1'b1;
      end
      OPC_BRANCH: begin
        imm       = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        d.in1_sel = USE_IN1_PC;
        d.jump_en = 1'b1;
        funct_alu = '0;
        rd_sel    = '0;
        rs2_used  = 1'b1;
      end
      OPC_LOAD: begin
        imm       = XLEN'($signed(inst[31:20]));
        d.rd_src  = USE_MEM;
        funct_alu = '0;
      end
      OPC_STORE: begin
        imm           = XLEN'($signed({inst[31:25], inst[11:7]}));
        d.data_mem_we = 1'b1;
        funct_alu     = '0;
        rd_sel        = '0;
        rs2_used      = 1'b1;
      end
      OPC_OP_IMM: begin
        imm = XLEN'($signed(inst[31:20]));
        if (f3 == FUNCT3_SLT || f3 == FUNCT3_SLTU) d.rd_src = USE_CMP;
        // Only shifts carry an ALU variant bit in funct7 for immediates.
        if (f3 == FUNCT3_SLL || f3 == FUNCT3_SR) funct_alu = {inst[30], f3};
      end
      OPC_OP: begin
        d.in2_sel = USE_IN2_RS2;
        funct_alu = {inst[30], f3};
        rs2_used  = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: imm = XLEN'($signed(inst[31:20]));
      default: ;
    endcase

    d.must_jump = ((opc == OPC_LOAD) || (opc == OPC_OP) || (opc == OPC_STORE) ||
                   (opc == OPC_SYSTEM)) && (f3 == FUNCT3_JUMP);

    if (illegal) begin
      d      = '0;
      rd_sel = '0;
    end
    decoded_op = d;
  end

endmodule

// File: rtl/instruction_decode_pipe.sv
// Handshaked decode stage: decodes into a DEPTH-entry output queue, with a
// load-use interlock (hazard block plus LU_BUBBLES dead cycles) and flush.
module instruction_decode_pipe
  import instruction_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int LU_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  curr_pc_fd,
  input  logic [XLEN-1:0]  next_pc_fd,
  output logic [4:0]       rs1sel,
  output logic [4:0]       rs2sel,
  input  logic [XLEN-1:0]  rs1data_rd,
  input  logic [XLEN-1:0]  rs2data_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  rs1data_de,
  output logic [XLEN-1:0]  rs2data_de,
  output logic [XLEN-1:0]  curr_pc_de,
  output logic [XLEN-1:0]  next_pc_de,
  output logic [3:0]       funct_alu,
  output logic [4:0]       rdsel_de,
  output logic [OPLEN-1:0] decoded_op_de,
  output logic             illegal_de,
  output logic             stall_decode
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1d;
    logic [XLEN-1:0]  rs2d;
    logic [XLEN-1:0]  cpc;
    logic [XLEN-1:0]  npc;
    logic [3:0]       falu;
    logic [4:0]       rd;
    logic [OPLEN-1:0] dop;
    logic             ill;
    logic             is_load;
  } ent_t;

  ent_t [DEPTH-1:0] q;
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ld_hit;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       bub_cnt;

  ent_t             new_ent;
  logic [XLEN-1:0]  dec_imm;
  logic [3:0]       dec_falu;
  logic [4:0]       dec_rd;
  logic [OPLEN-1:0] dec_op;
  logic             dec_ill, rs1_used, rs2_used;
  logic             hazard, push, pop;

  decode_core #(.XLEN(XLEN)) u_dec (
    .inst       (inst),
    .imm        (dec_imm),
    .funct_alu  (dec_falu),
    .rd_sel     (dec_rd),
    .decoded_op (dec_op),
    .illegal    (dec_ill),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used)
  );

  assign rs1sel = (inst[6:0] == OPC_LUI) ? 5'd0 : inst[19:15];
  assign rs2sel = inst[24:20];

  always_comb begin
    new_ent         = '0;
    new_ent.imm     = dec_imm;
    new_ent.rs1d    = rs1data_rd;
    new_ent.rs2d    = rs2data_rd;
    new_ent.cpc     = curr_pc_fd;
    new_ent.npc     = next_pc_fd;
    new_ent.falu    = dec_falu;
    new_ent.rd      = dec_rd;
    new_ent.dop     = dec_op;
    new_ent.ill     = dec_ill;
    new_ent.is_load = ~dec_ill & (inst[6:0] == OPC_LOAD) & (dec_rd != 5'd0);
  end

  // Every held LOAD is compared, not just the head, so a dependent never slips past.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign ld_hit[i] = ent_vld[i] & q[i].is_load &
                       ((rs1_used & (q[i].rd == rs1sel)) | (rs2_used & (q[i].rd == rs2sel)));
  end

  assign hazard       = |ld_hit;
  assign out_valid    = (count != '0);
  assign pop          = out_valid & out_ready;
  assign in_ready     = ((count != CW'(DEPTH)) | pop) & ~hazard & (bub_cnt == 2'd0) & ~flush;
  assign push         = in_valid & in_ready;
  assign stall_decode = in_valid & ~in_ready;

  assign imm           = q[rd_ptr].imm;
  assign rs1data_de    = q[rd_ptr].rs1d;
  assign rs2data_de    = q[rd_ptr].rs2d;
  assign curr_pc_de    = q[rd_ptr].cpc;
  assign next_pc_de    = q[rd_ptr].npc;
  assign funct_alu     = q[rd_ptr].falu;
  assign rdsel_de      = q[rd_ptr].rd;
  assign decoded_op_de = q[rd_ptr].dop;
  assign illegal_de    = q[rd_ptr].ill;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      ent_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      bub_cnt <= '0;
    end else if (flush) begin
      ent_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      bub_cnt <= '0;
    end else begin
      // Pop clears before push sets so a same-slot push at full survives.
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      if (push) begin
        q[wr_ptr]       <= new_ent;
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
      // Bubbles only follow the LOAD the offered instruction is actually waiting on.
      if (pop && in_valid && ld_hit[rd_ptr]) bub_cnt <= 2'(LU_BUBBLES);
      else if (bub_cnt != 2'd0)              bub_cnt <= bub_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Scoreboard bench for instruction_decode_pipe (XLEN=64, DEPTH=2, LU_BUBBLES=1).
module tb_instruction_decode_pipe;
  localparam int XLEN = 64;
  localparam int DEPTH = 2;
  localparam int LUB = 1;

  logic             clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]      inst = '0;
  logic [XLEN-1:0]  curr_pc_fd = '0, next_pc_fd = '0;
  logic             in_ready, out_valid, illegal_de, stall_decode;
  logic [4:0]       rs1sel, rs2sel, rdsel_de;
  logic [XLEN-1:0]  rs1data_rd, rs2data_rd;
  logic [XLEN-1:0]  imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de;
  logic [3:0]       funct_alu;
  logic [9:0]       decoded_op_de;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  falu;
    logic        ill;
    logic [9:0]  dop;
    logic [63:0] rs1d, rs2d, cpc, npc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          checks = 0, errors = 0;
  logic [63:0] pc = 64'h1000;
  int          s;

  function automatic logic [63:0] rf_val(input logic [4:0] sel);
    return (sel == 5'd0) ? 64'h0 : ({32'hC0DE_0000, 27'h0, sel} + 64'h100);
  endfunction

  assign rs1data_rd = rf_val(rs1sel);
  assign rs2data_rd = rf_val(rs2sel);

  instruction_decode_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .LU_BUBBLES(LUB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd),
    .rs1sel(rs1sel), .rs2sel(rs2sel), .rs1data_rd(rs1data_rd), .rs2data_rd(rs2data_rd),
    .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .rs1data_de(rs1data_de),
    .rs2data_de(rs2data_de), .curr_pc_de(curr_pc_de), .next_pc_de(next_pc_de),
    .funct_alu(funct_alu), .rdsel_de(rdsel_de), .decoded_op_de(decoded_op_de),
    .illegal_de(illegal_de), .stall_decode(stall_decode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1);
  end

  // Scoreboard monitor: push on accept, pop and compare on consume.
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output imm=%h rd=%0d (scoreboard empty)", imm, rdsel_de);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (imm !== e.imm) begin
            errors++; $display("FAIL head_imm actual=%h expected=%h", imm, e.imm);
          end
          checks++;
          if ({rdsel_de, funct_alu, illegal_de, decoded_op_de} !== {e.rd, e.falu, e.ill, e.dop}) begin
            errors++;
            $display("FAIL head_ctrl rd/falu/ill/dop actual=%0d/%h/%b/%h expected=%0d/%h/%b/%h",
                     rdsel_de, funct_alu, illegal_de, decoded_op_de, e.rd, e.falu, e.ill, e.dop);
          end
          checks++;
          if ({rs1data_de, rs2data_de} !== {e.rs1d, e.rs2d}) begin
            errors++;
            $display("FAIL head_rsdata actual=%h/%h expected=%h/%h", rs1data_de, rs2data_de, e.rs1d, e.rs2d);
          end
          checks++;
          if ({curr_pc_de, next_pc_de} !== {e.cpc, e.npc}) begin
            errors++;
            $display("FAIL head_pc actual=%h/%h expected=%h/%h", curr_pc_de, next_pc_de, e.cpc, e.npc);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic send(input logic [31:0] i, input logic [63:0] e_imm, input logic [4:0] e_rd,
                      input logic [3:0] e_falu, input logic e_ill, input logic [9:0] e_dop,
                      input logic [4:0] e_rs1, output int stalls);
    inst = i; in_valid = 1'b1; curr_pc_fd = pc; next_pc_fd = pc + 64'd4;
    cur_exp.imm = e_imm; cur_exp.rd = e_rd; cur_exp.falu = e_falu; cur_exp.ill = e_ill;
    cur_exp.dop = e_dop; cur_exp.rs1d = rf_val(e_rs1); cur_exp.rs2d = rf_val(i[24:20]);
    cur_exp.cpc = pc; cur_exp.npc = pc + 64'd4;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout inst=%h in_ready=%b required=1", i, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc = pc + 64'd4;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain pending=%0d out_valid=%b required=0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++;
    if ({imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de} !== '0) begin
      errors++; $display("FAIL reset_data actual imm=%h rs1=%h pc=%h expected=0", imm, rs1data_de, curr_pc_de);
    end
    checks++;
    if ({rdsel_de, funct_alu, decoded_op_de, illegal_de} !== '0) begin
      errors++; $display("FAIL reset_ctrl actual rd=%0d dop=%h expected=0", rdsel_de, decoded_op_de);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, stall_decode} !== 3'b100) begin
      errors++; $display("FAIL reset_release in_ready/out_valid/stall actual=%b required=100",
                         {in_ready, out_valid, stall_decode});
    end
  endtask

  task automatic test_addi();
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0050_0093, 64'd5, 5'd1, 4'd0, 1'b0, 10'h002, 5'd0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL addi_stalls actual=%0d expected=0", s); end
    @(negedge clk);
    checks++;
    if ({out_valid, imm, rdsel_de, funct_alu, illegal_de} !== {1'b1, 64'd5, 5'd1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL addi_head actual v=%b imm=%h rd=%0d falu=%h ill=%b expected v=1 imm=5 rd=1 falu=0 ill=0",
                         out_valid, imm, rdsel_de, funct_alu, illegal_de);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(32'hFFF0_8113, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 4'd0, 1'b0, 10'h002, 5'd1, s);
    send(32'h0031_2223, 64'd4, 5'd0, 4'd0, 1'b0, 10'h122, 5'd2, s);
    inst = 32'h8000_00B7; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, stall_decode, out_valid} !== 3'b011) begin
      errors++; $display("FAIL full_block in_ready/stall/out_valid actual=%b required=011",
                         {in_ready, stall_decode, out_valid});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 5'd1, 4'd0, 1'b0, 10'h002, 5'd0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL push_pop_at_full stalls actual=%0d expected=0", s); end
    send(32'h4031_D213, 64'h403, 5'd4, 4'hD, 1'b0, 10'h052, 5'd3, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL b2b_srai stalls actual=%0d expected=0", s); end
    drain();
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    send(32'h0001_2283, 64'd0, 5'd5, 4'd0, 1'b0, 10'h026, 5'd2, s);
    send(32'h0012_8333, 64'd0, 5'd6, 4'd0, 1'b0, 10'h000, 5'd5, s);
    checks++;
    if (s != 1 + LUB) begin errors++; $display("FAIL load_use_stalls actual=%0d expected=%0d", s, 1 + LUB); end
    send(32'h0010_0333, 64'd0, 5'd6, 4'd0, 1'b0, 10'h000, 5'd0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL after_hazard_stalls actual=%0d expected=0", s); end
    send(32'h0001_2003, 64'd0, 5'd0, 4'd0, 1'b0, 10'h026, 5'd2, s);
    send(32'h0000_0333, 64'd0, 5'd6, 4'd0, 1'b0, 10'h000, 5'd0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL load_x0_stalls actual=%0d expected=0", s); end
    // ADDI's imm field aliases rs2=x5; OP_IMM does not read rs2.
    send(32'h0001_2283, 64'd0, 5'd5, 4'd0, 1'b0, 10'h026, 5'd2, s);
    send(32'h0050_0093, 64'd5, 5'd1, 4'd0, 1'b0, 10'h002, 5'd0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL rs2_unused_stalls actual=%0d expected=0", s); end
    send(32'h0070_B193, 64'd7, 5'd3, 4'd3, 1'b0, 10'h03E, 5'd1, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL no_bubble_stalls actual=%0d expected=0", s); end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h0050_0093, 64'd5, 5'd1, 4'd0, 1'b0, 10'h002, 5'd0, s);
    send(32'h0070_B193, 64'd7, 5'd3, 4'd3, 1'b0, 10'h03E, 5'd1, s);
    out_ready = 1'b1;
    inst = 32'h0010_0333; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready actual=%b expected=0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid actual=%b expected=0", out_valid); end
    out_ready = 1'b1;
    send(32'h0010_0333, 64'd0, 5'd6, 4'd0, 1'b0, 10'h000, 5'd0, s);
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'h0000_007F, 64'd0, 5'd0, 4'd0, 1'b1, 10'h000, 5'd0, s);
    send(32'hFE00_0CE3, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 4'd0, 1'b0, 10'h083, 5'd0, s);
    send(32'h0050_0091, 64'd0, 5'd0, 4'd0, 1'b1, 10'h000, 5'd0, s);
    send(32'h0080_00EF, 64'd8, 5'd1, 4'd0, 1'b0, 10'h0BB, 5'd0, s);
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h0050_0093, 64'd5, 5'd1, 4'd0, 1'b0, 10'h002, 5'd0, s);
    inst = 32'hFFF0_8113; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, imm, rdsel_de} !== '0) begin
      errors++; $display("FAIL reset_mid actual v=%b imm=%h rd=%0d expected all 0", out_valid, imm, rdsel_de);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_mid_release out_valid/in_ready actual=%b expected=01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    send(32'h0050_0093, 64'd5, 5'd1, 4'd0, 1'b0, 10'h002, 5'd0, s);
    drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_pipe.md
# instruction_decode_pipe

Handshaked, parametrised decode stage for the RockWave core, replacing the phase-enable decode when the core runs pipelined. It accepts fetched instructions on a valid/ready interface and reads rs1/rs2 combinationally from register_file. Decoded results are held in a DEPTH-entry output queue. A load-use interlock inserts bubbles, flush discards all held state, and unsupported opcodes are flagged.

## Interface
- XLEN, 32, data/PC width (32 or 64)
- DEPTH, 2, output queue entries (2..4; 2 = skid buffer)
- LU_BUBBLES, 1, bubble cycles after a LOAD leaves the queue head (0..3)
- clk  in  1  CPU clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  discard queue and bubble counter this cycle
- in_valid  in  1  fetch offers inst
- in_ready  out  1  decode accepts this cycle
- inst  in  32  raw instruction
- curr_pc_fd / next_pc_fd  in  XLEN  PC of inst / successor PC
- rs1sel / rs2sel  out  5  register_file read selects (combinational from inst)
- rs1data_rd / rs2data_rd  in  XLEN  register_file read data, same cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  execute consumes head
- imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de  out  XLEN  head fields
- funct_alu  out  4  ALU select
- rdsel_de  out  5  destination register (0 for STORE/BRANCH)
- decoded_op_de  out  OPLEN  alu-in1/in2 select, rd source, funct3, jump_en, data_mem_we, must_jump
- illegal_de  out  1  head opcode not in RV32I base set
- stall_decode  out  1  in_valid & ~in_ready

## Operation
- Accept = in_valid & in_ready: decode inst, capture rs1/rs2 data and PCs, push to queue tail.
- Pop = out_valid & out_ready. Push and pop are allowed in the same cycle at any occupancy, including full.
- Decode rules: rs1sel forced to 0 for LUI. Funct3 is forced to the JUMP code for JAL/JALR. funct_alu is forced to 0 (ADD) for BRANCH/AUIPC/LOAD/STORE/LUI/JAL; otherwise it is {funct7[5] if OP or shift OP_IMM else 0, funct3}. Immediate is sign-extended to XLEN per I/S/B/U/J format. must_jump = op in {LOAD,OP,STORE,SYSTEM} & funct3 == JUMP code. rd source is: PC for JAL/JALR; memory for LOAD; compare for OP_IMM SLT/SLTU; ALU otherwise.
- Illegal: opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM, or inst[1:0] != 2'b11. The entry is queued with illegal set, rdsel forced 0, data_mem_we 0, jump_en 0.
- Load-use hazard: a queued LOAD with rd != 0 whose rd equals the used rs1 or rs2 of inst forces in_ready low. rs1 is unused for LUI/AUIPC/JAL; rs2 is used only for OP/STORE/BRANCH. When that LOAD pops, a counter loads LU_BUBBLES and in_ready stays low until it reaches 0.
- in_ready = ~full-after-pop & ~hazard & (bubble_cnt == 0) & ~flush.
- Flush: occupancy, pointers and bubble counter clear next edge. No push that cycle. A pop that cycle is still valid to the consumer.

## Timing
- Reset: out_valid 0, in_ready 1 after release, all data outputs 0, bubble counter 0, queue empty.
- Latency: accept at edge N → out_valid and fields valid after edge N (cycle N+1). Empty-queue throughput is 1/cycle with no bubbles.
- Outputs come straight from flops. in_ready is combinational from flops plus out_ready, inst and flush; it does not depend on in_valid.
- Head fields are stable while out_valid & ~out_ready.
- Pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH+1) bits.
- Reset asserted mid-transfer drops everything, with no partial entry.

## Structure
- core_general.vh: opcode localparams, FUNCT3_* codes, USE_* encodings, decoded_op bit positions, OPLEN; add ILLEGAL opcode list macro.
- Sub-module decode_core: purely combinational inst → {imm, funct_alu, rd_sel, decoded_op, illegal, rs1_used, rs2_used}, parametrised by XLEN.
- Queue and interlock live in the top module. obuf is not used because the queue replaces it.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, imm=5, rdsel_de=1, funct_alu=0, illegal_de=0.
- out_ready=0, four back-to-back instrs, DEPTH=2 → in_ready low after 2 accepts. Raise out_ready → order preserved and no loss when push and pop coincide at full.
- LW x5,0(x2) then ADD x6,x5,x1, LU_BUBBLES=1 → ADD held until LW pops plus 1 cycle. A following ADD x6,x0,x1 is not held.
- LW x0 then ADD x6,x0,x0 → no interlock.
- Queue holding 2 entries, flush=1 with in_valid=1 → in_ready=0 that cycle, out_valid=0 next cycle, input not queued.
- inst=0x0000007F, XLEN=64, then BEQ with negative offset −8 → illegal_de=1, rdsel_de=0. BEQ imm=0xFFFF_FFFF_FFFF_FFF8.
